// File: rtl/spi_boot_loader_pkg.sv
// Shared types and command codes for the SPI boot loader.
package spi_boot_pkg;

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, WRITE, SKIP} loader_state_t;

   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] CMD_RUN   = 8'h02;

endpackage

// File: rtl/spi_boot_loader_if.sv
// SPI pins on one side, RAM write port and status on the other.
interface spi_boot_loader_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic                  spi_sclk;
   logic                  spi_cs_n;
   logic                  spi_mosi;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  cpu_hold;
   logic                  cmd_err;
   logic [ADDR_WIDTH:0]   word_count;

   modport slave (
      input  spi_sclk, spi_cs_n, spi_mosi,
      output mem_we, mem_addr, mem_wdata, cpu_hold, cmd_err, word_count
   );

   modport master (
      output spi_sclk, spi_cs_n, spi_mosi,
      input  mem_we, mem_addr, mem_wdata, cpu_hold, cmd_err, word_count
   );
endinterface

// File: rtl/spi_byte_rx.sv
// Mode-0 SPI byte receiver: synchronisers, sclk rise detect, MSB-first shifter.
module spi_byte_rx (
   input  logic       clock,
   input  logic       reset,
   input  logic       i_sclk,
   input  logic       i_cs_n,
   input  logic       i_mosi,
   output logic       o_byte_valid,
   output logic [7:0] o_byte_data,
   output logic       o_frame_active
);
   logic [1:0] r_sclk_sync;
   logic [1:0] r_cs_sync;
   logic [1:0] r_mosi_sync;
   logic       r_sclk_prev;
   logic [2:0] r_bit_cnt;
   logic [6:0] r_shift;
   logic       w_rise;

   assign o_frame_active = ~r_cs_sync[1];
   // Edges outside a frame are ignored entirely.
   assign w_rise       = r_sclk_sync[1] & ~r_sclk_prev & o_frame_active;
   assign o_byte_valid = w_rise && (r_bit_cnt == 3'd7);
   assign o_byte_data  = {r_shift, r_mosi_sync[1]};

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_sclk_sync <= 2'b00;
         r_cs_sync   <= 2'b11;
         r_mosi_sync <= 2'b00;
         r_sclk_prev <= 1'b0;
         r_bit_cnt   <= 3'd0;
         r_shift     <= 7'd0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[0], i_sclk};
         r_cs_sync   <= {r_cs_sync[0], i_cs_n};
         r_mosi_sync <= {r_mosi_sync[0], i_mosi};
         r_sclk_prev <= r_sclk_sync[1];
         if (!o_frame_active) begin
            r_bit_cnt <= 3'd0;
         end else if (w_rise) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            r_shift   <= {r_shift[5:0], r_mosi_sync[1]};
         end
      end
   end
endmodule

// File: rtl/spi_boot_loader.sv
// SPI boot loader: fills program RAM over SPI and holds the CPU until RUN.
module spi_boot_loader
   import spi_boot_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic               clock,
   input  logic               reset,
   spi_boot_loader_if.slave   bus
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [ADDR_WIDTH:0] WC_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

   loader_state_t         r_state, w_next;
   logic                  w_byte_valid;
   logic [7:0]            w_byte_data;
   logic                  w_frame_active;
   logic [DATA_WIDTH-1:0] r_buf;
   logic [DATA_WIDTH-1:0] w_word;
   logic [BCW-1:0]        r_byte_cnt;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;
   logic                  r_cpu_hold;
   logic                  r_cmd_err;
   logic [ADDR_WIDTH:0]   r_word_count;

   spi_byte_rx u_rx (
      .clock          (clock),
      .reset          (reset),
      .i_sclk         (bus.spi_sclk),
      .i_cs_n         (bus.spi_cs_n),
      .i_mosi         (bus.spi_mosi),
      .o_byte_valid   (w_byte_valid),
      .o_byte_data    (w_byte_data),
      .o_frame_active (w_frame_active)
   );

   // First data byte ends up in the top byte after BYTES shifts.
   assign w_word = (r_buf << 8) | DATA_WIDTH'(w_byte_data);

   always_ff @(posedge clock) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:  if (w_frame_active) w_next = CMD;
         CMD: begin
            if (!w_frame_active)  w_next = IDLE;
            else if (w_byte_valid) w_next = (w_byte_data == CMD_WRITE) ? ADDR : SKIP;
         end
         ADDR: begin
            if (!w_frame_active)  w_next = IDLE;
            else if (w_byte_valid) w_next = DATA;
         end
         DATA: begin
            if (!w_frame_active) w_next = IDLE;
            else if (w_byte_valid && (r_byte_cnt == BCW'(BYTES - 1))) w_next = WRITE;
         end
         WRITE: w_next = w_frame_active ? DATA : IDLE;
         SKIP:  if (!w_frame_active) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_buf        <= '0;
         r_byte_cnt   <= '0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_cpu_hold   <= 1'b1;
         r_cmd_err    <= 1'b0;
         r_word_count <= '0;
      end else begin
         // Once the processor runs, words still decode but never reach RAM.
         r_mem_we <= (w_next == WRITE) && r_cpu_hold;
         if ((w_next == WRITE) && r_cpu_hold) r_mem_wdata <= w_word;
         case (r_state)
            CMD: begin
               if (w_byte_valid) begin
                  if (w_byte_data == CMD_RUN)        r_cpu_hold <= 1'b0;
                  else if (w_byte_data != CMD_WRITE) r_cmd_err  <= 1'b1;
               end
            end
            ADDR: begin
               r_byte_cnt <= '0;
               if (w_byte_valid) r_mem_addr <= ADDR_WIDTH'(w_byte_data);
            end
            DATA: begin
               if (w_byte_valid) begin
                  r_buf      <= w_word;
                  r_byte_cnt <= r_byte_cnt + 1'b1;
               end
            end
            WRITE: begin
               r_byte_cnt <= '0;
               r_mem_addr <= r_mem_addr + 1'b1;
               if (r_mem_we && (r_word_count != WC_MAX))
                  r_word_count <= r_word_count + 1'b1;
            end
            default: r_byte_cnt <= '0;
         endcase
      end
   end

   assign bus.mem_we     = r_mem_we;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_wdata  = r_mem_wdata;
   assign bus.cpu_hold   = r_cpu_hold;
   assign bus.cmd_err    = r_cmd_err;
   assign bus.word_count = r_word_count;
endmodule

// File: tb/tb_spi_boot_loader.sv
// Directed bench for spi_boot_loader: SPI frames in, RAM writes and status checked.
module tb_spi_boot_loader;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   we_cnt = 0;
   int   snap;
   logic [7:0]  wa [0:15];
   logic [31:0] wd [0:15];

   spi_boot_loader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bif ();

   spi_boot_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bif.slave)
   );

   always #5 clock = ~clock;

   // Every cycle mem_we is high is recorded, so a stretched pulse shows up as an extra write.
   always @(negedge clock) begin
      if (bif.mem_we !== 1'b0) begin
         wa[we_cnt[3:0]] = bif.mem_addr;
         wd[we_cnt[3:0]] = bif.mem_wdata;
         we_cnt = we_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic spi_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         bif.spi_mosi = b[i];
         cyc(5);
         bif.spi_sclk = 1'b1;
         cyc(5);
         bif.spi_sclk = 1'b0;
      end
   endtask

   task automatic cs_low();
      bif.spi_cs_n = 1'b0;
      cyc(5);
   endtask

   task automatic cs_high();
      cyc(5);
      bif.spi_cs_n = 1'b1;
      cyc(8);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      cyc(3);
      reset = 1'b1;
      cyc(2);
   endtask

   initial begin
      bif.spi_sclk = 1'b0;
      bif.spi_cs_n = 1'b1;
      bif.spi_mosi = 1'b0;
      cyc(4);
      chk("rst_we",    bif.mem_we, 1'b0);
      chk("rst_addr",  bif.mem_addr, 8'h00);
      chk("rst_wdata", bif.mem_wdata, 32'h0);
      chk("rst_hold",  bif.cpu_hold, 1'b1);
      chk("rst_err",   bif.cmd_err, 1'b0);
      chk("rst_wc",    bif.word_count, 9'd0);
      reset = 1'b1;
      cyc(2);

      // Single word write
      snap = we_cnt;
      cs_low();
      spi_byte(8'h01); spi_byte(8'h10);
      spi_byte(8'hDE); spi_byte(8'hAD); spi_byte(8'hBE); spi_byte(8'hEF);
      cs_high();
      chk("t1_npulse", 64'(we_cnt - snap), 64'd1);
      chk("t1_waddr",  wa[snap[3:0]], 8'h10);
      chk("t1_wdata",  wd[snap[3:0]], 32'hDEADBEEF);
      chk("t1_addr",   bif.mem_addr, 8'h11);
      chk("t1_wc",     bif.word_count, 9'd1);
      chk("t1_hold",   bif.cpu_hold, 1'b1);

      // Two words across the address wrap
      do_reset();
      snap = we_cnt;
      cs_low();
      spi_byte(8'h01); spi_byte(8'hFF);
      spi_byte(8'h11); spi_byte(8'h22); spi_byte(8'h33); spi_byte(8'h44);
      spi_byte(8'h55); spi_byte(8'h66); spi_byte(8'h77); spi_byte(8'h88);
      cs_high();
      chk("t2_npulse", 64'(we_cnt - snap), 64'd2);
      chk("t2_waddr0", wa[snap[3:0]], 8'hFF);
      chk("t2_wdata0", wd[snap[3:0]], 32'h11223344);
      chk("t2_waddr1", wa[4'(snap + 1)], 8'h00);
      chk("t2_wdata1", wd[4'(snap + 1)], 32'h55667788);
      chk("t2_wc",     bif.word_count, 9'd2);
      chk("t2_addr",   bif.mem_addr, 8'h01);

      // Partial word discarded, next frame clean
      snap = we_cnt;
      cs_low();
      spi_byte(8'h01); spi_byte(8'h20);
      spi_byte(8'hAA); spi_byte(8'hBB); spi_byte(8'hCC);
      cs_high();
      chk("t3_nopulse", 64'(we_cnt - snap), 64'd0);
      chk("t3_wc_hold", bif.word_count, 9'd2);
      cs_low();
      spi_byte(8'h01); spi_byte(8'h30);
      spi_byte(8'h01); spi_byte(8'h02); spi_byte(8'h03); spi_byte(8'h04);
      cs_high();
      chk("t3_npulse", 64'(we_cnt - snap), 64'd1);
      chk("t3_waddr",  wa[snap[3:0]], 8'h30);
      chk("t3_wdata",  wd[snap[3:0]], 32'h01020304);
      chk("t3_wc",     bif.word_count, 9'd3);

      // Unknown command then skipped bytes; error is sticky
      snap = we_cnt;
      cs_low();
      spi_byte(8'h7E); spi_byte(8'h01); spi_byte(8'h50);
      spi_byte(8'h12); spi_byte(8'h34); spi_byte(8'h56); spi_byte(8'h78);
      cs_high();
      chk("t5_err",     bif.cmd_err, 1'b1);
      chk("t5_nopulse", 64'(we_cnt - snap), 64'd0);
      cs_low();
      spi_byte(8'h01); spi_byte(8'h50);
      spi_byte(8'h12); spi_byte(8'h34); spi_byte(8'h56); spi_byte(8'h78);
      cs_high();
      chk("t5_npulse", 64'(we_cnt - snap), 64'd1);
      chk("t5_waddr",  wa[snap[3:0]], 8'h50);
      chk("t5_wdata",  wd[snap[3:0]], 32'h12345678);
      chk("t5_wc",     bif.word_count, 9'd4);
      chk("t5_err2",   bif.cmd_err, 1'b1);
      chk("t5_hold",   bif.cpu_hold, 1'b1);

      // RUN releases the CPU; later writes are blocked
      snap = we_cnt;
      cs_low();
      spi_byte(8'h02);
      chk("t4_hold_run", bif.cpu_hold, 1'b0);
      cs_high();
      cs_low();
      spi_byte(8'h01); spi_byte(8'h40);
      spi_byte(8'hA5); spi_byte(8'h5A); spi_byte(8'hC3); spi_byte(8'h3C);
      cs_high();
      chk("t4_nopulse", 64'(we_cnt - snap), 64'd0);
      chk("t4_wc",      bif.word_count, 9'd4);
      chk("t4_hold",    bif.cpu_hold, 1'b0);
      cs_low();
      spi_byte(8'h02);
      cs_high();
      chk("t4_hold_rerun", bif.cpu_hold, 1'b0);

      // Reset in the middle of a write frame
      snap = we_cnt;
      cs_low();
      spi_byte(8'h01); spi_byte(8'h70); spi_byte(8'hAA); spi_byte(8'hBB);
      reset = 1'b0;
      cyc(2);
      chk("t6_we",    bif.mem_we, 1'b0);
      chk("t6_addr",  bif.mem_addr, 8'h00);
      chk("t6_wdata", bif.mem_wdata, 32'h0);
      chk("t6_hold",  bif.cpu_hold, 1'b1);
      chk("t6_err",   bif.cmd_err, 1'b0);
      chk("t6_wc",    bif.word_count, 9'd0);
      bif.spi_cs_n = 1'b1;
      cyc(6);
      reset = 1'b1;
      cyc(2);
      cs_low();
      spi_byte(8'h01); spi_byte(8'h60);
      spi_byte(8'hCA); spi_byte(8'hFE); spi_byte(8'hF0); spi_byte(8'h0D);
      cs_high();
      chk("t6_npulse", 64'(we_cnt - snap), 64'd1);
      chk("t6_waddr",  wa[snap[3:0]], 8'h60);
      chk("t6_wdata",  wd[snap[3:0]], 32'hCAFEF00D);
      chk("t6_wc2",    bif.word_count, 9'd1);
      chk("t6_addr2",  bif.mem_addr, 8'h61);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/spi_boot_loader.md
Name: spi_boot_loader

Overview:
- SPI slave that fills the single-port program/data RAM before the processor runs.
- Holds the processor in reset until released by an SPI RUN command.
- Sits upstream of the processor: top level muxes the RAM port between loader (cpu_hold=1) and processor (cpu_hold=0).

Parameters:
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 32, RAM word width; must be a multiple of 8; BYTES = DATA_WIDTH/8.

Ports:
- clock  input  1  system clock.
- reset  input  1  reset, synchronous, active-low.
- spi_sclk  input  1  SPI clock, asynchronous to clock.
- spi_cs_n  input  1  SPI chip select, active-low, asynchronous.
- spi_mosi  input  1  SPI data in, asynchronous.
- mem_we  output  1  RAM write strobe.
- mem_addr  output  ADDR_WIDTH  RAM write address.
- mem_wdata  output  DATA_WIDTH  RAM write data.
- cpu_hold  output  1  1 = processor held in reset and RAM owned by loader.
- cmd_err  output  1  sticky flag: unknown command byte received.
- word_count  output  ADDR_WIDTH+1  words written since reset, saturating.

Behaviour:
- Reset (reset=0 at a clock edge):
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=1, cmd_err=0, word_count=0.
  - State IDLE; bit, byte and shift counters cleared.
- Input synchronisation:
  - sclk, cs_n and mosi each pass through a 2-FF synchroniser.
  - Rising edge of sclk is detected on the synchronised signal.
  - SPI mode 0, MSB first; mosi is sampled on the detected sclk rise.
  - sclk high and low phases must each be ≥4 clock periods.
- Frame: starts at cs_n falling and ends at cs_n rising.
  - First byte = command:
    - 0x01 WRITE;
    - 0x02 RUN;
    - anything else = error.
- FSM states: IDLE, CMD, ADDR, DATA, WRITE, SKIP.
  - IDLE -> CMD on synchronised cs_n low.
  - CMD, 8 bits complete:
    - 0x01 -> ADDR;
    - 0x02 -> cpu_hold<=0, then SKIP;
    - other -> cmd_err<=1, then SKIP.
  - ADDR, 8 bits complete -> mem_addr<=byte, then DATA.
    - For ADDR_WIDTH<8 use the low bits; for ADDR_WIDTH>8 zero-extend.
  - DATA: bytes shift into the word buffer MSB-first (first byte -> bits [DATA_WIDTH-1:DATA_WIDTH-8]). After BYTES bytes -> WRITE.
  - WRITE lasts one cycle:
    - mem_we=1, mem_wdata=buffer, mem_addr unchanged;
    - next cycle mem_addr<=mem_addr+1 modulo 2^ADDR_WIDTH (255 wraps to 0);
    - word_count increments, saturating at 2^ADDR_WIDTH;
    - then back to DATA.
  - SKIP ignores all bits until cs_n rises.
- mem_we:
  - high exactly one cycle per completed word;
  - that cycle is 1 clock after the sclk-rise detection of the word's last bit;
  - zero at all other times.
- cs_n rises in any state -> IDLE next cycle.
  - A partial byte or partial word is discarded; no write occurs.
  - A WRITE already in progress still completes its single cycle.
- RUN while cpu_hold=0: no effect.
  - Once cpu_hold=0, WRITE commands still decode but mem_we stays 0 (processor owns RAM); their words are not counted.
  - cpu_hold returns to 1 only via reset.
- sclk edges while cs_n high are ignored.
- Reset mid-frame: immediate return to reset values. The RAM is untouched beyond words already written.

Decomposition:
- Package spi_boot_pkg holds:
  - typedef enum logic [2:0] loader_state_t {IDLE, CMD, ADDR, DATA, WRITE, SKIP};
  - constants CMD_WRITE=8'h01, CMD_RUN=8'h02.
- One sub-module, spi_byte_rx:
  - performs synchronisers, edge detect, bit counter and shift register;
  - outputs byte_valid (1-cycle pulse), byte_data[7:0] and frame_active;
  - clears its bit counter when frame_active drops.
- FSM, address/word logic and counters live in spi_boot_loader.

Test Plan:
- Reset then frame 01 10 DE AD BE EF -> one mem_we pulse with mem_addr=0x10, mem_wdata=DEADBEEF; afterwards mem_addr=0x11, word_count=1, cpu_hold=1.
- Frame 01 FF + 8 data bytes (11223344, 55667788) -> writes at 0xFF then 0x00 (wrap); word_count=2.
- Frame 01 20 AA BB CC, cs_n raised mid-word -> no mem_we; next frame 01 30 01020304 writes 0x30 only.
- Frame 02, then 01 40 + one word -> cpu_hold falls after the 8th bit of 02; no mem_we afterwards; word_count unchanged.
- Frame 7E followed by 01 50 + 4 bytes in the same frame -> cmd_err=1 sticky, no write; next frame 01 50 12345678 writes correctly.
- Reset asserted after 2 data bytes of a WRITE frame -> all outputs at reset values; subsequent clean frame writes normally.
